dividend_rebuild: RTL and testbench

DIVIDEND_REBUILD -- requirements
Module: dividend_rebuild

---
 rtl/dividend_rebuild_pkg.sv | 16 +
 rtl/dividend_rebuild_if.sv | 29 ++
 rtl/dividend_rebuild.sv | 114 +++++++++++
 tb/tb_dividend_rebuild.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dividend_rebuild_pkg.sv
// Shared types and constants for the dividend rebuild block (A = Q*B + R).
// Holds the controller state encoding and the default operand width.
// Optional build macro used by the block: DIVIDEND_REBUILD_EARLY_EXIT_EN.
package dividend_rebuild_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for a request, shift-and-add, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dividend_rebuild_if.sv
// Operand/result bundle for dividend_rebuild.
// Ports: start, Q, B, R flow requester -> block; A, ok, err, busy flow back.
// master = requester side, slave = dividend_rebuild side.
interface dividend_rebuild_if
  import dividend_rebuild_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;  // level request, only looked at while idle
  logic [WIDTH-1:0] Q;      // quotient operand
  logic [WIDTH-1:0] B;      // divisor operand
  logic [WIDTH-1:0] R;      // remainder operand
  logic [WIDTH-1:0] A;      // rebuilt dividend, truncated to WIDTH bits
  logic             ok;     // result valid and consistent
  logic             err;    // result invalid: overflow or R >= B
  logic             busy;   // operation in progress

  modport master (
    output start, Q, B, R,
    input  A, ok, err, busy
  );

  modport slave (
    input  start, Q, B, R,
    output A, ok, err, busy
  );

endinterface

// File: rtl/dividend_rebuild.sv
// Purpose: rebuilds a dividend A = Q*B + R with a serial shift-and-add and flags
//   overflow or an out-of-range remainder (R >= B) as err, otherwise ok.
// Latency: WIDTH+1 edges after start is sampled; with DIVIDEND_REBUILD_EARLY_EXIT_EN
//   defined, the run stops as soon as the remaining quotient bits are all zero.
// Backpressure: none; a held start never retriggers, the result is held until start
//   drops, and a new operation needs start low then high again.
// Ports: clk, reset_n (async, active-low), bus (dividend_rebuild_if.slave).
module dividend_rebuild
  import dividend_rebuild_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  dividend_rebuild_if.slave  bus
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   q_sh;     // remaining quotient bits, LSB consumed first
  logic [2*WIDTH-1:0] b_sh;     // divisor weighted by the current quotient bit
  logic [2*WIDTH-1:0] acc;      // running Q*B + R; cannot wrap at 2*WIDTH bits
  logic [CW-1:0]      cnt;      // quotient bits consumed so far
  // The remainder check only ever needs R >= B, so the comparison is taken once
  // when the operands are latched instead of keeping both operands around.
  logic               r_ge_b;

  logic [WIDTH-1:0]   a_q;
  logic               ok_q;
  logic               err_q;

  logic               run_done;
  logic               err_calc;

`ifdef DIVIDEND_REBUILD_EARLY_EXIT_EN
  // Once no quotient bits are left, further steps cannot change acc.
  assign run_done = (cnt == CNT_LAST) || (q_sh == '0);
`else
  assign run_done = (cnt == CNT_LAST);
`endif

  // Any bit above WIDTH means the truncated A is not the true dividend.
  assign err_calc = (acc[2*WIDTH-1:WIDTH] != '0) || r_ge_b;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (run_done)  state_nxt = DONE;
      DONE:    if (!bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      q_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      r_ge_b <= 1'b0;
      a_q    <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_sh   <= bus.Q;
            b_sh   <= {{WIDTH{1'b0}}, bus.B};
            acc    <= {{WIDTH{1'b0}}, bus.R};
            cnt    <= '0;
            r_ge_b <= (bus.R >= bus.B);
          end
        end
        RUN: begin
          if (run_done) begin
            a_q   <= acc[WIDTH-1:0];
            err_q <= err_calc;
            ok_q  <= !err_calc;
          end else begin
            if (q_sh[0]) acc <= acc + b_sh;
            b_sh <= b_sh << 1;
            q_sh <= q_sh >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Flags drop on the way back to IDLE; A keeps the last result.
          if (!bus.start) begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A    = a_q;
  assign bus.ok   = ok_q;
  assign bus.err  = err_q;
  assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_dividend_rebuild.sv
// Bench for dividend_rebuild at WIDTH=8: directed table, reset/hold sequences and
// random operands checked against a plain-arithmetic model of Q*B+R.
module tb_dividend_rebuild;
  import dividend_rebuild_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset_n;

  dividend_rebuild_if #(.WIDTH(W)) bus ();

  dividend_rebuild #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic         ok;
    logic         err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the start-sampling edge to the first edge showing the result.
  function automatic int exp_lat(input logic [W-1:0] q);
    int h;
`ifdef DIVIDEND_REBUILD_EARLY_EXIT_EN
    h = -1;
    for (int i = 0; i < W; i++) if (q[i]) h = i;
    return (h < 0) ? 1 : h + 2;
`else
    h = 0;
    return W + 1 + h;
`endif
  endfunction

  // Runs one operation with start held for 'hold' cycles after the result shows.
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic [W-1:0] ea,
                        input logic eok, input logic eerr, input int hold,
                        input string tag);
    int  k;
    bit  done;
    bit  busy_bad;
    bit  hold_bad;
    bus.Q = q; bus.B = b; bus.R = r; bus.start = 1'b1;
    step();  // edge 0 samples start
    // Operands are free to change once captured.
    bus.Q = W'($urandom); bus.B = W'($urandom); bus.R = W'($urandom);
    k = 0; done = 0; busy_bad = 0;
    while (!done && k < 3 * W + 5) begin
      step();
      k++;
      if (bus.ok || bus.err) done = 1;
      else if (!bus.busy) busy_bad = 1;
    end
    chk({tag, "_latency"}, k, exp_lat(q));
    chk({tag, "_busy_run"}, busy_bad, 0);
    chk({tag, "_A"}, bus.A, ea);
    chk({tag, "_ok"}, bus.ok, eok);
    chk({tag, "_err"}, bus.err, eerr);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.A !== ea || bus.ok !== eok || bus.err !== eerr || bus.busy !== 1'b0 ||
          (bus.ok && bus.err)) hold_bad = 1;
    end
    if (hold > 0) chk({tag, "_hold"}, hold_bad, 0);
    bus.start = 1'b0;
    step();
    chk({tag, "_ok_clr"}, bus.ok, 0);
    chk({tag, "_err_clr"}, bus.err, 0);
    chk({tag, "_A_keep"}, bus.A, ea);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A0"}, bus.A, 0);
    chk({tag, "_ok0"}, bus.ok, 0);
    chk({tag, "_err0"}, bus.err, 0);
    chk({tag, "_busy0"}, bus.busy, 0);
  endtask

  initial begin
    logic [W-1:0] q, b, r, ea;
    logic         eerr;
    longint       p;
    int           k;

    tbl[0] = '{q: 8'd6,   b: 8'd10,  r: 8'd4,   a: 8'd64,  ok: 1'b1, err: 1'b0};
    tbl[1] = '{q: 8'd30,  b: 8'd10,  r: 8'd5,   a: 8'd49,  ok: 1'b0, err: 1'b1};
    tbl[2] = '{q: 8'd3,   b: 8'd0,   r: 8'd0,   a: 8'd0,   ok: 1'b0, err: 1'b1};
    tbl[3] = '{q: 8'd2,   b: 8'd5,   r: 8'd5,   a: 8'd15,  ok: 1'b0, err: 1'b1};
    tbl[4] = '{q: 8'd255, b: 8'd255, r: 8'd254, a: 8'd255, ok: 1'b0, err: 1'b1};
    tbl[5] = '{q: 8'd0,   b: 8'd7,   r: 8'd3,   a: 8'd3,   ok: 1'b1, err: 1'b0};
    tbl[6] = '{q: 8'd1,   b: 8'd10,  r: 8'd4,   a: 8'd14,  ok: 1'b1, err: 1'b0};
    tbl[7] = '{q: 8'd15,  b: 8'd17,  r: 8'd0,   a: 8'd255, ok: 1'b1, err: 1'b0};
    tbl[8] = '{q: 8'd16,  b: 8'd16,  r: 8'd0,   a: 8'd0,   ok: 1'b0, err: 1'b1};
    tbl[9] = '{q: 8'd128, b: 8'd2,   r: 8'd1,   a: 8'd1,   ok: 1'b0, err: 1'b1};

    bus.start = 1'b0; bus.Q = '0; bus.B = '0; bus.R = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    step(); step();
    reset_n = 1'b1;
    step();
    chk_zero("post_reset");

    // Directed table.
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].q, tbl[i].b, tbl[i].r, tbl[i].a, tbl[i].ok, tbl[i].err,
             i % 3, $sformatf("vec%0d", i));

    // Reset in the middle of a run: nothing partial may show.
    bus.Q = 8'd6; bus.B = 8'd10; bus.R = 8'd4; bus.start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    #1 chk_zero("rst_run");
    bus.start = 1'b0;
    step();
    chk_zero("rst_run_hold");
    reset_n = 1'b1;
    step();
    run_op(8'd6, 8'd10, 8'd4, 8'd64, 1'b1, 1'b0, 0, "restart");

    // Reset while a result is held in DONE.
    bus.Q = 8'd2; bus.B = 8'd5; bus.R = 8'd5; bus.start = 1'b1;
    step();
    k = 0;
    while (!(bus.ok || bus.err) && k < 3 * W + 5) begin step(); k++; end
    chk("done_A_before_rst", bus.A, 15);
    reset_n = 1'b0;
    #1 chk_zero("rst_done");
    bus.start = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Start held for 30 cycles gives exactly one operation; next start is fresh.
    run_op(8'd6, 8'd10, 8'd4, 8'd64, 1'b1, 1'b0, 30, "held");
    run_op(8'd7, 8'd3, 8'd2, 8'd23, 1'b1, 1'b0, 0, "next");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      q = W'($urandom);
      b = W'($urandom);
      r = W'($urandom);
      if (i % 4 == 0) r = W'($urandom_range(0, 15));
      if (i % 7 == 0) q = W'($urandom_range(0, 3));
      p    = longint'(q) * longint'(b) + longint'(r);
      ea   = p[W-1:0];
      eerr = ((p >> W) != 0) || (r >= b);
      run_op(q, b, r, ea, !eerr, eerr, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
